// File: rtl/rx_tlp_sender_pkg.sv
// Shared constants, state/mode types and TLP helpers for the rx TLP sender.
package rx_tlp_sender_pkg;

  localparam int BF     = 9;
  localparam int RD_AW  = BF + 1;
  localparam int MAX_QW = 16;
  localparam int QW_W   = $clog2(MAX_QW + 1);

  localparam logic [18:0] HDR_RSVD_QW    = 19'd16;
  localparam logic [6:0]  MWR64_FMT_TYPE = 7'b11_00000;

  typedef enum logic [8:0] {
    ST_IDLE      = 9'b0_0000_0001,
    ST_WAIT_PAGE = 9'b0_0000_0010,
    ST_HDR0      = 9'b0_0000_0100,
    ST_HDR1      = 9'b0_0000_1000,
    ST_DATA      = 9'b0_0001_0000,
    ST_C_HDR0    = 9'b0_0010_0000,
    ST_C_HDR1    = 9'b0_0100_0000,
    ST_C_DATA    = 9'b0_1000_0000,
    ST_SWITCH    = 9'b1_0000_0000
  } state_e;

  typedef enum logic [1:0] {
    MODE_TRIG = 2'd0,
    MODE_LAST = 2'd1,
    MODE_CHG  = 2'd2
  } mode_e;

  // Host expects each DW little-endian while the buffer holds them big-endian.
  function automatic logic [63:0] dw_bswap(input logic [63:0] q);
    return {q[39:32], q[47:40], q[55:48], q[63:56],
            q[7:0],   q[15:8],  q[23:16], q[31:24]};
  endfunction

  function automatic logic [63:0] mwr64_hdr0(input logic [9:0]  len_dw,
                                             input logic [15:0] rid,
                                             input logic [7:0]  tag);
    return {1'b0, MWR64_FMT_TYPE, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00,
            len_dw, rid, tag, 8'hFF};
  endfunction

endpackage

// File: rtl/rx_tlp_sender_prefetch.sv
// Two-entry skid FIFO hiding the one-cycle buffer read latency; the head can be
// taken straight off rd_data so an unstalled TLP streams at one qword per cycle.
module rx_tlp_sender_prefetch
  import rx_tlp_sender_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [QW_W-1:0]  load_qw_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [63:0]      data_o,
  output logic [RD_AW-1:0] rd_addr_o,
  input  logic [63:0]      rd_data_i
);

  logic [QW_W-1:0]  remaining_q;
  logic             inflight_q;
  logic [1:0]       cnt_q;
  logic             head_q;
  logic [63:0]      mem_q [2];
  logic [RD_AW-1:0] rd_addr_q;

  logic rd_en_s;
  logic push_s;
  logic pop_mem_s;
  logic tail_s;

  // A read is issued only when stored plus in-flight qwords leave room for it.
  assign rd_en_s   = (remaining_q != '0) && (({1'b0, cnt_q} + {2'b00, inflight_q}) <= 3'd1);
  assign pop_mem_s = pop_i && (cnt_q != 2'd0);
  assign push_s    = inflight_q && !(pop_i && (cnt_q == 2'd0));
  assign tail_s    = head_q ^ cnt_q[0];
  assign valid_o   = (cnt_q != 2'd0) || inflight_q;
  assign data_o    = (cnt_q != 2'd0) ? mem_q[head_q] : rd_data_i;
  assign rd_addr_o = rd_addr_q;

  // Read issue, in-flight tracking and FIFO storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      cnt_q       <= 2'd0;
      head_q      <= 1'b0;
      mem_q[0]    <= 64'd0;
      mem_q[1]    <= 64'd0;
      rd_addr_q   <= '0;
    end else begin
      inflight_q <= rd_en_s;
      if (load_i) begin
        remaining_q <= load_qw_i;
      end else if (rd_en_s) begin
        remaining_q <= remaining_q - {{(QW_W-1){1'b0}}, 1'b1};
      end
      if (rd_en_s) begin
        rd_addr_q <= rd_addr_q + {{(RD_AW-1){1'b0}}, 1'b1};
      end
      if (push_s) begin
        mem_q[tail_s] <= rd_data_i;
      end
      if (pop_mem_s) begin
        head_q <= ~head_q;
      end
      cnt_q <= cnt_q + {1'b0, push_s} - {1'b0, pop_mem_s};
    end
  end

endmodule

// File: rtl/rx_tlp_sender.sv
// Emits MWr64 TLPs from the rx buffer into the active host huge page and closes
// pages by writing their qword count into the reserved header qword.
module rx_tlp_sender
  import rx_tlp_sender_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             trigger_tlp,
  output logic             trigger_tlp_ack,
  input  logic             change_huge_page,
  input  logic             send_last_tlp,
  output logic             change_huge_page_ack,
  input  logic [QW_W-1:0]  qwords_to_send,
  input  logic [63:0]      huge_page_addr_1,
  input  logic [63:0]      huge_page_addr_2,
  input  logic             huge_page_status_1,
  input  logic             huge_page_status_2,
  output logic             huge_page_unlock_1,
  output logic             huge_page_unlock_2,
  output logic [RD_AW-1:0] rd_addr,
  input  logic [63:0]      rd_data,
  input  logic [15:0]      cfg_completer_id,
  output logic [63:0]      trn_td,
  output logic [7:0]       trn_trem_n,
  output logic             trn_tsof_n,
  output logic             trn_teof_n,
  output logic             trn_tsrc_rdy_n,
  input  logic             trn_tdst_rdy_n
);

  state_e          state_q;
  mode_e           mode_q;
  logic [QW_W-1:0] qw_q;
  logic [QW_W-1:0] data_cnt_q;
  logic            page2_q;
  logic [18:0]     qw_off_q;
  logic [7:0]      tag_q;
  logic [63:0]     td_q;
  logic            tsof_n_q;
  logic            teof_n_q;
  logic            tsrc_rdy_n_q;
  logic            trig_ack_q;
  logic            chg_ack_q;
  logic            unlock1_q;
  logic            unlock2_q;

  logic [63:0] page_base_s;
  logic        page_ready_s;
  logic        beat_ok_s;
  logic [9:0]  data_len_s;
  logic [63:0] hdr1_addr_s;
  logic        pf_load_s;
  logic        pf_pop_s;
  logic        pf_valid_s;
  logic [63:0] pf_data_s;

  assign page_base_s  = page2_q ? huge_page_addr_2 : huge_page_addr_1;
  assign page_ready_s = page2_q ? huge_page_status_2 : huge_page_status_1;
  assign beat_ok_s    = !tsrc_rdy_n_q && !trn_tdst_rdy_n;
  assign data_len_s   = {4'b0000, qw_q, 1'b0};
  assign hdr1_addr_s  = page_base_s + {42'd0, qw_off_q, 3'b000};
  assign pf_load_s    = (state_q == ST_WAIT_PAGE) && page_ready_s && (mode_q != MODE_CHG);
  // The next data qword is consumed when the beat in front of it is accepted.
  assign pf_pop_s     = beat_ok_s && pf_valid_s &&
                        ((state_q == ST_HDR1) || ((state_q == ST_DATA) && teof_n_q));

  rx_tlp_sender_prefetch u_prefetch (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (pf_load_s),
    .load_qw_i (qw_q),
    .pop_i     (pf_pop_s),
    .valid_o   (pf_valid_s),
    .data_o    (pf_data_s),
    .rd_addr_o (rd_addr),
    .rd_data_i (rd_data)
  );

  // Sequencer: every TRN output is loaded one state ahead so it is held during stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_TRIG;
      qw_q         <= '0;
      data_cnt_q   <= '0;
      page2_q      <= 1'b0;
      qw_off_q     <= HDR_RSVD_QW;
      tag_q        <= 8'd0;
      td_q         <= 64'd0;
      tsof_n_q     <= 1'b1;
      teof_n_q     <= 1'b1;
      tsrc_rdy_n_q <= 1'b1;
      trig_ack_q   <= 1'b0;
      chg_ack_q    <= 1'b0;
      unlock1_q    <= 1'b0;
      unlock2_q    <= 1'b0;
    end else begin
      trig_ack_q <= 1'b0;
      chg_ack_q  <= 1'b0;
      unlock1_q  <= 1'b0;
      unlock2_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A request is still high while its own ack is visible; do not re-accept it.
          if (!trig_ack_q && !chg_ack_q) begin
            if (change_huge_page) begin
              mode_q  <= MODE_CHG;
              state_q <= ST_WAIT_PAGE;
            end else if (send_last_tlp) begin
              mode_q  <= MODE_LAST;
              qw_q    <= qwords_to_send;
              state_q <= ST_WAIT_PAGE;
            end else if (trigger_tlp) begin
              mode_q  <= MODE_TRIG;
              qw_q    <= qwords_to_send;
              state_q <= ST_WAIT_PAGE;
            end
          end
        end
        ST_WAIT_PAGE: begin
          if (page_ready_s) begin
            tsrc_rdy_n_q <= 1'b0;
            tsof_n_q     <= 1'b0;
            data_cnt_q   <= '0;
            if (mode_q == MODE_CHG) begin
              td_q    <= mwr64_hdr0(10'd2, cfg_completer_id, tag_q);
              state_q <= ST_C_HDR0;
            end else begin
              td_q    <= mwr64_hdr0(data_len_s, cfg_completer_id, tag_q);
              state_q <= ST_HDR0;
            end
          end
        end
        ST_HDR0: begin
          if (beat_ok_s) begin
            tsof_n_q <= 1'b1;
            td_q     <= hdr1_addr_s;
            state_q  <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (beat_ok_s) begin
            td_q       <= dw_bswap(pf_data_s);
            teof_n_q   <= !(qw_q == {{(QW_W-1){1'b0}}, 1'b1});
            data_cnt_q <= {{(QW_W-1){1'b0}}, 1'b1};
            state_q    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat_ok_s) begin
            if (!teof_n_q) begin
              qw_off_q <= qw_off_q + {{(19-QW_W){1'b0}}, qw_q};
              tag_q    <= tag_q + 8'd1;
              teof_n_q <= 1'b1;
              if (mode_q == MODE_LAST) begin
                td_q     <= mwr64_hdr0(10'd2, cfg_completer_id, tag_q + 8'd1);
                tsof_n_q <= 1'b0;
                state_q  <= ST_C_HDR0;
              end else begin
                tsrc_rdy_n_q <= 1'b1;
                trig_ack_q   <= trigger_tlp;
                state_q      <= ST_IDLE;
              end
            end else begin
              td_q       <= dw_bswap(pf_data_s);
              teof_n_q   <= !((data_cnt_q + {{(QW_W-1){1'b0}}, 1'b1}) == qw_q);
              data_cnt_q <= data_cnt_q + {{(QW_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_C_HDR0: begin
          if (beat_ok_s) begin
            tsof_n_q <= 1'b1;
            td_q     <= page_base_s;
            state_q  <= ST_C_HDR1;
          end
        end
        ST_C_HDR1: begin
          if (beat_ok_s) begin
            td_q     <= {45'd0, qw_off_q};
            teof_n_q <= 1'b0;
            state_q  <= ST_C_DATA;
          end
        end
        ST_C_DATA: begin
          if (beat_ok_s) begin
            teof_n_q     <= 1'b1;
            tsrc_rdy_n_q <= 1'b1;
            state_q      <= ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          unlock1_q <= !page2_q;
          unlock2_q <= page2_q;
          page2_q   <= !page2_q;
          qw_off_q  <= HDR_RSVD_QW;
          chg_ack_q <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: begin
          tsof_n_q     <= 1'b1;
          teof_n_q     <= 1'b1;
          tsrc_rdy_n_q <= 1'b1;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign trigger_tlp_ack      = trig_ack_q;
  assign change_huge_page_ack = chg_ack_q;
  assign huge_page_unlock_1   = unlock1_q;
  assign huge_page_unlock_2   = unlock2_q;
  assign trn_td               = td_q;
  assign trn_trem_n           = 8'h00;
  assign trn_tsof_n           = tsof_n_q;
  assign trn_teof_n           = teof_n_q;
  assign trn_tsrc_rdy_n       = tsrc_rdy_n_q;

endmodule

// File: tb/tb_rx_tlp_sender.sv
// Directed bench for rx_tlp_sender: a page/offset/tag model builds the expected
// TRN beat stream, a monitor checks every accepted beat, literals pin the model.
module tb_rx_tlp_sender;
  import rx_tlp_sender_pkg::*;

  localparam int DEPTH = 1 << RD_AW;
  localparam logic [63:0] P1 = 64'h0000_0000_1000_0000;
  localparam logic [63:0] P2 = 64'h0000_0002_3450_0000;

  typedef struct packed {logic [63:0] td; logic sof; logic eof;} beat_t;
  typedef struct packed {logic [63:0] hdr0; logic [63:0] hdr1; logic [63:0] last; logic [7:0] nb;} tlp_t;

  logic clk, reset_n;
  logic trigger_tlp, trigger_tlp_ack, change_huge_page, send_last_tlp, change_huge_page_ack;
  logic [4:0] qwords_to_send;
  logic [63:0] huge_page_addr_1, huge_page_addr_2;
  logic huge_page_status_1, huge_page_status_2, huge_page_unlock_1, huge_page_unlock_2;
  logic [RD_AW-1:0] rd_addr;
  logic [63:0] rd_data;
  logic [15:0] cfg_completer_id;
  logic [63:0] trn_td;
  logic [7:0] trn_trem_n;
  logic trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tdst_rdy_n;

  rx_tlp_sender dut (
    .clk(clk), .reset_n(reset_n),
    .trigger_tlp(trigger_tlp), .trigger_tlp_ack(trigger_tlp_ack),
    .change_huge_page(change_huge_page), .send_last_tlp(send_last_tlp),
    .change_huge_page_ack(change_huge_page_ack), .qwords_to_send(qwords_to_send),
    .huge_page_addr_1(huge_page_addr_1), .huge_page_addr_2(huge_page_addr_2),
    .huge_page_status_1(huge_page_status_1), .huge_page_status_2(huge_page_status_2),
    .huge_page_unlock_1(huge_page_unlock_1), .huge_page_unlock_2(huge_page_unlock_2),
    .rd_addr(rd_addr), .rd_data(rd_data), .cfg_completer_id(cfg_completer_id),
    .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
    .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tdst_rdy_n(trn_tdst_rdy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] bram [DEPTH];
  always @(posedge clk) rd_data <= bram[rd_addr];

  int total = 0, bad = 0;
  int trig_acks = 0, chg_acks = 0, unl1 = 0, unl2 = 0;
  int cur_nb = 0;
  bit stall_en = 0;
  beat_t expq[$];
  tlp_t tlp_log[$];
  int m_page, m_off, m_tag, m_rd;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- model ----
  function automatic logic [63:0] m_hdr0(input int len_dw, input int tag);
    logic [9:0] len;
    logic [7:0] t;
    len = len_dw[9:0];
    t = tag[7:0];
    // R, fmt=MWr64, type, R, TC, R, TD, EP, attr, R, length | requester, tag, BEs
    return {1'b0, 2'b11, 5'b00000, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, len,
            cfg_completer_id, t, 4'hF, 4'hF};
  endfunction

  function automatic logic [63:0] m_swap(input logic [63:0] d);
    return {d[39:32], d[47:40], d[55:48], d[63:56], d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [63:0] m_base();
    return (m_page == 1) ? P1 : P2;
  endfunction

  task automatic m_data(input int n);
    expq.push_back('{m_hdr0(2 * n, m_tag), 1'b1, 1'b0});
    expq.push_back('{m_base() + 64'(m_off) * 64'd8, 1'b0, 1'b0});
    for (int i = 0; i < n; i++)
      expq.push_back('{m_swap(bram[(m_rd + i) % DEPTH]), 1'b0, (i == n - 1)});
    m_off += n;
    m_tag = (m_tag + 1) % 256;
    m_rd = (m_rd + n) % DEPTH;
  endtask

  task automatic m_close();
    expq.push_back('{m_hdr0(2, m_tag), 1'b1, 1'b0});
    expq.push_back('{m_base(), 1'b0, 1'b0});
    expq.push_back('{64'(m_off), 1'b0, 1'b1});
    m_page = 3 - m_page;
    m_off = 16;
  endtask

  // ---- destination-ready driver ----
  initial begin
    trn_tdst_rdy_n = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      trn_tdst_rdy_n = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // ---- compare process: every accepted beat against the model, holds during stalls ----
  initial begin
    bit prev_stall;
    logic [66:0] prev_out;
    beat_t e;
    tlp_t cur;
    prev_stall = 0;
    prev_out = '0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 0;
        cur_nb = 0;
        continue;
      end
      if (trigger_tlp_ack) trig_acks++;
      if (change_huge_page_ack) chg_acks++;
      if (huge_page_unlock_1) unl1++;
      if (huge_page_unlock_2) unl2++;
      if (prev_stall)
        chk("stall_hold", 128'({trn_td, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n}), 128'(prev_out));
      if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got td=%h with no beat expected", trn_td);
        end else begin
          e = expq.pop_front();
          chk("beat", {trn_td, trn_tsof_n, trn_teof_n, trn_trem_n},
              {e.td, !e.sof, !e.eof, 8'h00});
        end
        if (!trn_tsof_n) begin
          cur_nb = 1;
          cur.hdr0 = trn_td;
        end else begin
          cur_nb++;
          if (cur_nb == 2) cur.hdr1 = trn_td;
        end
        if (!trn_teof_n) begin
          cur.last = trn_td;
          cur.nb = 8'(cur_nb);
          tlp_log.push_back(cur);
        end
      end
      prev_stall = !trn_tsrc_rdy_n && trn_tdst_rdy_n;
      prev_out = {trn_td, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n};
    end
  end

  // ---- stimulus helpers ----
  task automatic start_req(input int kind, input int n);
    qwords_to_send = n[4:0];
    if (kind == 0) trigger_tlp = 1'b1;
    else if (kind == 1) send_last_tlp = 1'b1;
    else change_huge_page = 1'b1;
  endtask

  task automatic wait_ack(input int kind);
    bit got;
    got = 0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      got = (kind == 0) ? trigger_tlp_ack : change_huge_page_ack;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: got no ack required ack for kind %0d", kind);
    end
    trigger_tlp = 1'b0;
    send_last_tlp = 1'b0;
    change_huge_page = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && expq.size() != 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("queue_drained", 128'(expq.size()), 128'd0);
  endtask

  task automatic get_tlp(output tlp_t t);
    total++;
    if (tlp_log.size() == 0) begin
      bad++;
      $display("FAIL tlp_missing: got 0 logged TLPs required 1");
      t = '0;
    end else begin
      t = tlp_log.pop_front();
    end
  endtask

  task automatic run(input int kind, input int n);
    if (kind == 0) m_data(n);
    else if (kind == 1) begin m_data(n); m_close(); end
    else m_close();
    start_req(kind, n);
    wait_ack(kind);
    drain();
  endtask

  initial begin
    tlp_t t;
    bit ok;
    int k;
    reset_n = 1'b0;
    trigger_tlp = 1'b0;
    send_last_tlp = 1'b0;
    change_huge_page = 1'b0;
    qwords_to_send = 5'd1;
    huge_page_addr_1 = P1;
    huge_page_addr_2 = P2;
    huge_page_status_1 = 1'b1;
    huge_page_status_2 = 1'b1;
    cfg_completer_id = 16'h0A5C;
    for (int i = 0; i < DEPTH; i++) bram[i] = {$urandom, $urandom};
    m_page = 1; m_off = 16; m_tag = 0; m_rd = 0;

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        128'({trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, rd_addr,
              trigger_tlp_ack, change_huge_page_ack, huge_page_unlock_1, huge_page_unlock_2}),
        128'({64'd0, 8'h00, 1'b1, 1'b1, 1'b1, {RD_AW{1'b0}}, 4'b0000}));
    reset_n = 1'b1;
    @(negedge clk);

    // 1: 16 qwords, no stalls
    run(0, 16);
    get_tlp(t);
    chk("t1_beats", 128'(t.nb), 128'd18);
    chk("t1_hdr1", 128'(t.hdr1), 128'(64'h0000_0000_1000_0080));
    chk("t1_len", 128'(t.hdr0[41:32]), 128'd32);
    chk("t1_rd_addr", 128'(rd_addr), 128'd16);
    chk("t1_acks", 128'(trig_acks), 128'd1);

    // 2: same request under random stalls
    stall_en = 1;
    run(0, 16);
    stall_en = 0;
    get_tlp(t);
    chk("t2_beats", 128'(t.nb), 128'd18);
    chk("t2_hdr1", 128'(t.hdr1), 128'(64'h0000_0000_1000_0100));
    chk("t2_acks", 128'(trig_acks), 128'd2);

    // 3: page not yet writable
    huge_page_status_1 = 1'b0;
    m_data(16);
    start_req(0, 16);
    ok = 1;
    repeat (100) begin
      @(negedge clk);
      if (!trn_tsrc_rdy_n) ok = 0;
    end
    chk("t3_quiet_wait", 128'(ok), 128'd1);
    huge_page_status_1 = 1'b1;
    k = 0;
    for (int i = 0; i < 10 && (k == 0); i++) begin
      @(negedge clk);
      if (!trn_tsof_n) k = i + 1;
    end
    chk("t3_start_latency_ok", 128'(k >= 1 && k <= 3), 128'd1);
    wait_ack(0);
    drain();
    get_tlp(t);
    chk("t3_hdr1", 128'(t.hdr1), 128'(64'h0000_0000_1000_0180));

    // 4: send_last with 5 qwords closes page 1
    run(1, 5);
    get_tlp(t);
    chk("t4_len", 128'(t.hdr0[41:32]), 128'd10);
    get_tlp(t);
    chk("t4_close_addr", 128'(t.hdr1), 128'(64'h0000_0000_1000_0000));
    chk("t4_close_data", 128'(t.last), 128'h45);
    chk("t4_close_beats", 128'(t.nb), 128'd3);
    chk("t4_pulses", 128'({unl1, unl2, chg_acks, trig_acks}), 128'({32'd1, 32'd0, 32'd1, 32'd3}));
    run(0, 3);
    get_tlp(t);
    chk("t4_page2_hdr1", 128'(t.hdr1), 128'(64'h0000_0002_3450_0080));
    run(2, 0);
    get_tlp(t);
    chk("t4_unlock2", 128'(unl2), 128'd1);

    // 5: close page 1 with nothing written
    run(2, 0);
    get_tlp(t);
    chk("t5_close_data", 128'(t.last), 128'h10);
    chk("t5_pulses", 128'({unl1, chg_acks, trig_acks}), 128'({32'd2, 32'd3, 32'd4}));

    // request withdrawn mid-TLP: TLP completes, no ack
    m_data(4);
    start_req(0, 4);
    for (int i = 0; i < 50 && trn_tsof_n; i++) @(negedge clk);
    trigger_tlp = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    get_tlp(t);
    chk("drop_no_ack", 128'(trig_acks), 128'd4);

    // 6: reset during data beat 7
    m_data(16);
    start_req(0, 16);
    for (int i = 0; i < 200 && cur_nb < 9; i++) begin
      @(negedge clk);
      #1;
    end
    chk("t6_reached_beat7", 128'(cur_nb), 128'd9);
    reset_n = 1'b0;
    trigger_tlp = 1'b0;
    expq.delete();
    m_page = 1; m_off = 16; m_tag = 0; m_rd = 0;
    @(posedge clk);
    #1;
    chk("t6_reset_outputs",
        128'({trn_td, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, rd_addr, trigger_tlp_ack}),
        128'({64'd0, 1'b1, 1'b1, 1'b1, {RD_AW{1'b0}}, 1'b0}));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run(0, 2);
    get_tlp(t);
    chk("t6_tag0", 128'(t.hdr0[15:8]), 128'd0);
    chk("t6_page1", 128'(t.hdr1), 128'(64'h0000_0000_1000_0080));
    chk("t6_acks", 128'(trig_acks), 128'd5);
    chk("no_extra_tlps", 128'(tlp_log.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
